// File: rtl/prng_pkg.sv
// Shared types and defaults for the PRNG packetizer: FSM states, byte width and header default.
package prng_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [BYTE_W-1:0] HDR_BYTE_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HDR  = 3'd1,
    ST_SEQ  = 3'd2,
    ST_PAY  = 3'd3,
    ST_CSUM = 3'd4
  } state_e;

endpackage

// File: rtl/pkt_csum_acc.sv
// Running mod-256 byte sum; clear has priority over add.
module pkt_csum_acc
  import prng_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              clear_i,
  input  logic              add_en_i,
  input  logic [BYTE_W-1:0] data_i,
  output logic [BYTE_W-1:0] sum_o
);

  logic [BYTE_W-1:0] sum_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else if (clear_i) begin
      sum_q <= '0;
    end else if (add_en_i) begin
      sum_q <= sum_q + data_i;
    end
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/prng_packetizer.sv
// Emits packets of HDR, SEQ, PAYLOAD_LEN random bytes and a checksum over a valid/ready byte stream.
module prng_packetizer
  import prng_pkg::*;
#(
  parameter int unsigned       PAYLOAD_LEN = 4,
  parameter logic [BYTE_W-1:0] HDR_BYTE    = HDR_BYTE_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [BYTE_W-1:0] rnd_in,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [BYTE_W-1:0] pkt_count
);

  state_e            state_q, state_d;
  logic [BYTE_W-1:0] data_q, data_d;
  logic [BYTE_W-1:0] cnt_q, cnt_d;
  logic [BYTE_W-1:0] beat_q, beat_d;
  logic [BYTE_W-1:0] seq_q, seq_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic              acc_clear, acc_add;
  logic [BYTE_W-1:0] csum;
  logic              xfer;
  logic              last_beat;

  assign xfer      = valid_q & out_ready;
  assign last_beat = (beat_q == BYTE_W'(PAYLOAD_LEN - 1));

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: only IDLE looks at start, every other hop waits for a transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start)             state_d = ST_HDR;
      ST_HDR:  if (xfer)              state_d = ST_SEQ;
      ST_SEQ:  if (xfer)              state_d = ST_PAY;
      ST_PAY:  if (xfer && last_beat) state_d = ST_CSUM;
      ST_CSUM: if (xfer)              state_d = ST_IDLE;
      default:                        state_d = ST_IDLE;
    endcase
  end

  // Output / datapath next values; each SEQ or payload byte is summed as it is loaded
  always_comb begin
    data_d    = data_q;
    beat_d    = beat_q;
    seq_d     = seq_q;
    cnt_d     = cnt_q;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          data_d    = HDR_BYTE;
          seq_d     = cnt_q;
          beat_d    = '0;
          acc_clear = 1'b1;
        end
      end
      ST_HDR: begin
        if (xfer) begin
          data_d  = seq_q;
          acc_add = 1'b1;
        end
      end
      ST_SEQ: begin
        if (xfer) begin
          data_d  = rnd_in;
          beat_d  = '0;
          acc_add = 1'b1;
        end
      end
      ST_PAY: begin
        if (xfer) begin
          if (last_beat) begin
            data_d = csum;
          end else begin
            data_d  = rnd_in;
            beat_d  = beat_q + BYTE_W'(1);
            acc_add = 1'b1;
          end
        end
      end
      ST_CSUM: begin
        if (xfer) begin
          data_d = '0;
          cnt_d  = cnt_q + BYTE_W'(1);
        end
      end
      default: data_d = '0;
    endcase
    valid_d = (state_d != ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    last_d  = (state_d == ST_CSUM);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_q  <= '0;
      cnt_q   <= '0;
      beat_q  <= '0;
      seq_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      beat_q  <= beat_d;
      seq_q   <= seq_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  pkt_csum_acc u_csum (
    .clk      (clk),
    .reset    (reset),
    .clear_i  (acc_clear),
    .add_en_i (acc_add),
    .data_i   (data_d),
    .sum_o    (csum)
  );

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign busy      = busy_q;
  assign pkt_count = cnt_q;

endmodule

// File: tb/tb_prng_packetizer.sv
// Bench for prng_packetizer: directed vector table, hand sequences and a random run against a packet-level model.
module tb_prng_packetizer;
  import prng_pkg::*;

  localparam int unsigned L   = 4;
  localparam logic [7:0]  HDR = HDR_BYTE_DEFAULT;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic [7:0] rnd_in;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic [7:0] pkt_count;

  always #5 clk = ~clk;

  prng_packetizer #(.PAYLOAD_LEN(L), .HDR_BYTE(HDR)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .rnd_in    (rnd_in),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last),
    .busy      (busy),
    .pkt_count (pkt_count)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packet-level reference: every accepted byte is collected and a finished packet is
  // compared with HDR, the model's sequence number, the rnd_in values seen at its
  // transfer edges 1..L, and their mod-256 sum.
  logic [7:0] m_seq;
  logic [7:0] q_data[$];
  logic [7:0] q_rnd[$];
  logic       q_last[$];
  bit         pend_cnt;
  bit         prev_stall;
  logic [7:0] prev_data;
  logic       prev_last;

  task automatic check_packet();
    logic [7:0]  sum;
    logic [31:0] lastv;
    check("pkt_len", 32'(q_data.size()), 32'(L + 3));
    if (q_data.size() == L + 3) begin
      check("pkt_hdr", 32'(q_data[0]), 32'(HDR));
      check("pkt_seq", 32'(q_data[1]), 32'(m_seq));
      sum = m_seq;
      for (int k = 0; k < int'(L); k++) begin
        check($sformatf("pkt_pay%0d", k), 32'(q_data[2 + k]), 32'(q_rnd[1 + k]));
        sum = sum + q_rnd[1 + k];
      end
      check("pkt_csum", 32'(q_data[L + 2]), 32'(sum));
      lastv = '0;
      for (int k = 0; k < int'(L + 3); k++) lastv[k] = q_last[k];
      check("pkt_last", lastv, 32'(1) << (L + 2));
    end
    m_seq    = m_seq + 8'd1;
    pend_cnt = 1'b1;
    q_data.delete();
    q_rnd.delete();
    q_last.delete();
  endtask

  always @(negedge clk) begin
    if (reset) begin
      m_seq      = 8'h00;
      pend_cnt   = 1'b0;
      prev_stall = 1'b0;
      q_data.delete();
      q_rnd.delete();
      q_last.delete();
    end else begin
      if (pend_cnt) begin
        check("pkt_count", 32'(pkt_count), 32'(m_seq));
        pend_cnt = 1'b0;
      end
      if (prev_stall)
        check("stall_hold", 32'({out_valid, out_last, out_data}), 32'({1'b1, prev_last, prev_data}));
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      if (out_valid && out_ready) begin
        q_data.push_back(out_data);
        q_rnd.push_back(rnd_in);
        q_last.push_back(out_last);
        if (out_last || q_data.size() >= L + 3) check_packet();
      end
    end
  end

  typedef struct {
    logic       start;
    logic       ready;
    logic [7:0] rnd;
    logic       exp_valid;
    logic [7:0] exp_data;
    logic       exp_last;
    logic [7:0] exp_cnt;
  } vec_t;

  function automatic vec_t mk(logic s, logic r, logic [7:0] d, logic ev, logic [7:0] ed,
                              logic el, logic [7:0] ec);
    vec_t v;
    v.start = s; v.ready = r; v.rnd = d;
    v.exp_valid = ev; v.exp_data = ed; v.exp_last = el; v.exp_cnt = ec;
    return v;
  endfunction

  task automatic send_packet(output logic [7:0] seq);
    start = 1'b1; out_ready = 1'b1; rnd_in = 8'($urandom);
    step();
    start = 1'b0; rnd_in = 8'($urandom);
    step();
    seq = out_data;
    for (int n = 0; n < 100 && busy; n++) begin
      rnd_in = 8'($urandom);
      step();
    end
    check("pkt_done", 32'(busy), 32'(0));
  endtask

  task automatic pulse_reset();
    #2 reset = 1'b1;
    #1;
    @(posedge clk);
    #1 reset = 1'b0;
    step();
  endtask

  vec_t       vecs[$];
  logic [7:0] seq;

  initial begin
    reset = 1'b1; start = 1'b0; out_ready = 1'b0; rnd_in = 8'h00;
    #3;
    check("rst_state", 32'({out_valid, out_last, busy, out_data, pkt_count}), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    step();

    // Columns: start, ready, rnd driven this cycle | expected valid, data, last, count now
    vecs.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b0, 8'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h10, 1'b1, 8'h00, 1'b0, 8'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h20, 1'b1, 8'h10, 1'b0, 8'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h30, 1'b1, 8'h20, 1'b0, 8'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h40, 1'b1, 8'h30, 1'b0, 8'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h99, 1'b1, 8'h40, 1'b0, 8'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 8'hA0, 1'b1, 8'd0));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd1));
    // Second packet: stalled for three clocks on payload beat 2, start pulsed during PAY and CSUM
    vecs.push_back(mk(1'b1, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b1, 8'hA5, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h10, 1'b1, 8'h01, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h20, 1'b1, 8'h10, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h55, 1'b1, 8'h20, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h66, 1'b1, 8'h20, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 1'b0, 8'h77, 1'b1, 8'h20, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h30, 1'b1, 8'h20, 1'b0, 8'd1));
    vecs.push_back(mk(1'b1, 1'b1, 8'h40, 1'b1, 8'h30, 1'b0, 8'd1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h88, 1'b1, 8'h40, 1'b0, 8'd1));
    vecs.push_back(mk(1'b1, 1'b1, 8'h00, 1'b1, 8'hA1, 1'b1, 8'd1));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd2));
    vecs.push_back(mk(1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 8'd2));

    for (int i = 0; i < vecs.size(); i++) begin
      check($sformatf("vec%0d", i),
            32'({out_valid, out_last, busy, (out_valid ? out_data : 8'h00), pkt_count}),
            32'({vecs[i].exp_valid, vecs[i].exp_last, vecs[i].exp_valid,
                 (vecs[i].exp_valid ? vecs[i].exp_data : 8'h00), vecs[i].exp_cnt}));
      start = vecs[i].start; out_ready = vecs[i].ready; rnd_in = vecs[i].rnd;
      step();
    end

    // Reset in the middle of the payload
    start = 1'b1; out_ready = 1'b1;
    step();
    start = 1'b0;
    repeat (3) begin
      rnd_in = 8'($urandom);
      step();
    end
    check("pre_reset_valid", 32'(out_valid), 32'(1));
    #2 reset = 1'b1;
    #1;
    check("mid_reset_state", 32'({out_valid, out_last, busy, out_data, pkt_count}), 32'(0));
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    check("no_resume", 32'({out_valid, busy}), 32'(0));
    send_packet(seq);
    check("post_reset_seq", 32'(seq), 32'(0));
    step();
    check("post_reset_cnt", 32'(pkt_count), 32'(1));

    // Sequence-number wrap over 256 packets
    pulse_reset();
    for (int p = 0; p < 256; p++) begin
      if (p == 255) check("cnt_before_256", 32'(pkt_count), 32'(8'hFF));
      send_packet(seq);
      if (p == 255) check("seq_of_256", 32'(seq), 32'(8'hFF));
    end
    step();
    check("cnt_wrapped", 32'(pkt_count), 32'(0));

    // Random traffic with random backpressure
    for (int c = 0; c < 3000; c++) begin
      start     = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rnd_in    = 8'($urandom);
      step();
    end
    start = 1'b0; out_ready = 1'b1;
    for (int n = 0; n < 50 && busy; n++) step();
    check("drain_idle", 32'(busy), 32'(0));
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
